// File: rtl/lag_wrr_tree_arbiter_pkg.sv
// Shared widths and helper functions for the LAG weighted tree arbiter.
package lag_arb_pkg;

    // Upper bound on any flattened vector handed to the helpers below.
    localparam int unsigned MAX_BITS = 256;

    // Index width that stays at least one bit for single-entry pools.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_SIZE      = 20;
    localparam int unsigned DEF_GROUPSIZE = 4;
    localparam int unsigned GIDX_W        = idx_w(DEF_SIZE / DEF_GROUPSIZE);
    localparam int unsigned LIDX_W        = idx_w(DEF_GROUPSIZE);

    // Effective burst weight of group g; a zero field behaves as one.
    function automatic int unsigned weight_field(input logic [MAX_BITS-1:0] w,
                                                 input int unsigned g,
                                                 input int unsigned ww);
        int unsigned f;
        f = 0;
        for (int unsigned b = 0; b < ww; b++) begin
            if (w[g*ww + b]) f = f | (32'd1 << b);
        end
        return (f == 0) ? 1 : f;
    endfunction

    function automatic logic [MAX_BITS-1:0] idx2oh(input int unsigned i);
        logic [MAX_BITS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned oh2idx(input logic [MAX_BITS-1:0] v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/lag_wrr_tree_arbiter_if.sv
// Request/grant bundle between requesters and the weighted tree arbiter.
interface lag_wrr_tree_arbiter_if #(
    parameter int unsigned SIZE      = 20,
    parameter int unsigned GROUPSIZE = 4,
    parameter int unsigned WEIGHT_W  = 4
);
    localparam int unsigned NUMGROUPS = SIZE / GROUPSIZE;

    logic [SIZE-1:0]               request;
    logic [NUMGROUPS*WEIGHT_W-1:0] weight;
    logic                          success;
    logic                          lock;
    logic [SIZE-1:0]               grant;
    logic                          grant_valid;
    logic                          held;

    modport master (output request, weight, success, lock,
                    input  grant, grant_valid, held);
    modport slave  (input  request, weight, success, lock,
                    output grant, grant_valid, held);
endinterface

// File: rtl/lag_wrr_tree_arbiter_rr.sv
// Combinational pointer-based round-robin pick over N requests.
module rr_ptr_arb
    import lag_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = idx_w(N)
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    // First requester at or above ptr, wrapping modulo N.
    always_comb begin
        int unsigned j;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/lag_wrr_tree_arbiter.sv
// Two-level tree arbiter: per-group round robin, weighted round robin
// between groups, and an optional grant hold for multi-beat transfers.
module lag_wrr_tree_arbiter
    import lag_arb_pkg::*;
#(
    parameter int unsigned SIZE      = 20,
    parameter int unsigned GROUPSIZE = 4,
    parameter int unsigned WEIGHT_W  = 4,
    parameter int unsigned HOLD_EN   = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    lag_wrr_tree_arbiter_if.slave bus
);
    localparam int unsigned NUMGROUPS = SIZE / GROUPSIZE;
    localparam int unsigned G_W       = idx_w(NUMGROUPS);
    localparam int unsigned L_W       = idx_w(GROUPSIZE);
    localparam int unsigned I_W       = idx_w(SIZE);

    logic [L_W-1:0]       rr_ptr [NUMGROUPS];
    logic [L_W-1:0]       rr_nxt [NUMGROUPS];
    logic [G_W-1:0]       gptr, gptr_nxt;
    logic [WEIGHT_W-1:0]  cnt, cnt_nxt;
    logic                 held_q, held_nxt;
    logic [I_W-1:0]       held_idx, held_idx_nxt;

    logic [GROUPSIZE-1:0] grp_gnt [NUMGROUPS];
    logic [L_W-1:0]       grp_idx [NUMGROUPS];
    logic [NUMGROUPS-1:0] grp_any, win_oh;
    logic [G_W-1:0]       win, upd_grp;
    logic [SIZE-1:0]      arb_grant, grant_int;
    logic [I_W-1:0]       arb_idx, cur_idx;
    logic [L_W-1:0]       cur_local;
    logic [MAX_BITS-1:0]  weight_ext, held_oh;
    logic                 hold_live, lock_eff, do_upd;

    for (genvar g = 0; g < NUMGROUPS; g++) begin : g_grp
        assign grp_any[g] = |bus.request[g*GROUPSIZE +: GROUPSIZE];
        rr_ptr_arb #(.N(GROUPSIZE)) u_grp (
            .ptr (rr_ptr[g]),
            .req (bus.request[g*GROUPSIZE +: GROUPSIZE]),
            .gnt (grp_gnt[g]),
            .idx (grp_idx[g])
        );
    end

    rr_ptr_arb #(.N(NUMGROUPS)) u_sel (
        .ptr (gptr),
        .req (grp_any),
        .gnt (win_oh),
        .idx (win)
    );

    assign lock_eff  = (HOLD_EN != 0) && bus.lock;
    assign hold_live = held_q && bus.request[held_idx];

    // Combine the winning group's pick into the flat grant; a live hold overrides it.
    always_comb begin
        arb_grant  = '0;
        arb_idx    = '0;
        for (int unsigned g = 0; g < NUMGROUPS; g++) begin
            if (win_oh[g]) begin
                arb_grant[g*GROUPSIZE +: GROUPSIZE] = grp_gnt[g];
                arb_idx = I_W'(g*GROUPSIZE) + I_W'(grp_idx[g]);
            end
        end
        held_oh    = idx2oh(32'(held_idx));
        weight_ext = '0;
        weight_ext[NUMGROUPS*WEIGHT_W-1:0] = bus.weight;
        grant_int  = hold_live ? held_oh[SIZE-1:0] : arb_grant;
        cur_idx    = hold_live ? held_idx : arb_idx;
        upd_grp    = hold_live ? G_W'(32'(held_idx) / GROUPSIZE) : win;
        cur_local  = L_W'(32'(cur_idx) % GROUPSIZE);
    end

    assign bus.grant       = grant_int;
    assign bus.grant_valid = |bus.request;
    assign bus.held        = held_q;

    // Next state: lock entry freezes pointers; the burst's release applies one normal update.
    always_comb begin
        int unsigned base;
        rr_nxt       = rr_ptr;
        gptr_nxt     = gptr;
        cnt_nxt      = cnt;
        held_nxt     = hold_live;
        held_idx_nxt = held_idx;
        do_upd       = 1'b0;
        base         = 0;
        if (bus.success && (|grant_int)) begin
            if (hold_live) begin
                if (!lock_eff) begin
                    held_nxt = 1'b0;
                    do_upd   = 1'b1;
                end
            end else if (lock_eff && !held_q) begin
                held_nxt     = 1'b1;
                held_idx_nxt = cur_idx;
            end else begin
                do_upd = 1'b1;
            end
        end
        if (do_upd) begin
            rr_nxt[upd_grp] = L_W'((32'(cur_local) + 1) % GROUPSIZE);
            base = (upd_grp == gptr) ? 32'(cnt) : 0;
            if (base + 1 >= weight_field(weight_ext, 32'(upd_grp), WEIGHT_W)) begin
                gptr_nxt = G_W'((32'(upd_grp) + 1) % NUMGROUPS);
                cnt_nxt  = '0;
            end else begin
                gptr_nxt = upd_grp;
                cnt_nxt  = WEIGHT_W'(base + 1);
            end
        end
    end

    // Arbitration state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned g = 0; g < NUMGROUPS; g++) rr_ptr[g] <= '0;
            gptr     <= '0;
            cnt      <= '0;
            held_q   <= 1'b0;
            held_idx <= '0;
        end else begin
            rr_ptr   <= rr_nxt;
            gptr     <= gptr_nxt;
            cnt      <= cnt_nxt;
            held_q   <= held_nxt;
            held_idx <= held_idx_nxt;
        end
    end

endmodule

// File: tb/tb_lag_wrr_tree_arbiter.sv
// Directed self-checking bench for lag_wrr_tree_arbiter (SIZE=8, GROUPSIZE=4).
module tb_lag_wrr_tree_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lag_wrr_tree_arbiter_if #(.SIZE(8), .GROUPSIZE(4), .WEIGHT_W(4)) bus ();

    lag_wrr_tree_arbiter #(
        .SIZE(8), .GROUPSIZE(4), .WEIGHT_W(4), .HOLD_EN(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // weight byte: upper nibble is group 1, lower nibble is group 0
    task automatic apply_reset(input logic [7:0] w);
        rst_n       = 1'b0;
        bus.success = 1'b0;
        bus.lock    = 1'b0;
        bus.weight  = w;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.weight = 8'h12; bus.success = 1'b0; bus.lock = 1'b0;
        bus.request = 8'hFF; #1;
        checks++; if (bus.grant !== 8'h01) begin errors++; $display("FAIL reset_grant: got %h expected 01", bus.grant); end
        checks++; if (bus.held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", bus.held); end
        checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b expected 1", bus.grant_valid); end
        bus.request = 8'h00; #1;
        checks++; if (bus.grant !== 8'h00) begin errors++; $display("FAIL reset_nogrant: got %h expected 00", bus.grant); end
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_novalid: got %b expected 0", bus.grant_valid); end
        bus.request = 8'hA0; #1;
        checks++; if (bus.grant !== 8'h20) begin errors++; $display("FAIL reset_g1only: got %h expected 20", bus.grant); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_weighted_rotation();
        logic [7:0] seq [8];
        seq = '{8'h01, 8'h02, 8'h10, 8'h04, 8'h08, 8'h20, 8'h01, 8'h02};
        apply_reset(8'h12);
        bus.request = 8'hFF; bus.success = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.grant !== seq[i]) begin errors++; $display("FAIL rotation[%0d]: got %h expected %h", i, bus.grant, seq[i]); end
            tick();
        end
    endtask

    task automatic test_no_success();
        apply_reset(8'h12);
        bus.request = 8'hFF; bus.success = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.grant !== 8'h01) begin errors++; $display("FAIL idle_hold[%0d]: got %h expected 01", i, bus.grant); end
            tick();
        end
        bus.success = 1'b1;
        tick();
        checks++; if (bus.grant !== 8'h02) begin errors++; $display("FAIL idle_then_success: got %h expected 02", bus.grant); end
    endtask

    task automatic test_success_without_grant();
        apply_reset(8'h12);
        bus.request = 8'h00; bus.success = 1'b1; #1;
        tick(); tick();
        bus.request = 8'hFF; bus.success = 1'b0; #1;
        checks++; if (bus.grant !== 8'h01) begin errors++; $display("FAIL empty_success: got %h expected 01", bus.grant); end
    endtask

    task automatic test_zero_weights();
        logic [7:0] seq [6];
        seq = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h04, 8'h40};
        apply_reset(8'h00);
        bus.request = 8'hFF; bus.success = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.grant !== seq[i]) begin errors++; $display("FAIL zero_weight[%0d]: got %h expected %h", i, bus.grant, seq[i]); end
            tick();
        end
    endtask

    task automatic test_lock_burst();
        apply_reset(8'h12);
        bus.request = 8'hFF; bus.success = 1'b1; bus.lock = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.grant !== 8'h01) begin errors++; $display("FAIL lock_grant[%0d]: got %h expected 01", i, bus.grant); end
            tick();
            checks++; if (bus.held !== 1'b1) begin errors++; $display("FAIL lock_held[%0d]: got %b expected 1", i, bus.held); end
        end
        bus.lock = 1'b0; #1;
        checks++; if (bus.grant !== 8'h01) begin errors++; $display("FAIL lock_last_beat: got %h expected 01", bus.grant); end
        tick();
        checks++; if (bus.grant !== 8'h02) begin errors++; $display("FAIL lock_release_grant: got %h expected 02", bus.grant); end
        checks++; if (bus.held !== 1'b0) begin errors++; $display("FAIL lock_release_held: got %b expected 0", bus.held); end
        // one more success: burst counted as a single beat, so g0 weight 2 is now spent
        tick();
        checks++; if (bus.grant !== 8'h10) begin errors++; $display("FAIL lock_weight_count: got %h expected 10", bus.grant); end
        bus.success = 1'b0;
    endtask

    task automatic test_hold_abandon();
        apply_reset(8'h12);
        bus.request = 8'hFF; bus.success = 1'b1; bus.lock = 1'b1; #1;
        tick();
        bus.success = 1'b0; bus.lock = 1'b0; bus.request = 8'hFE; #1;
        checks++; if (bus.grant !== 8'h02) begin errors++; $display("FAIL abandon_grant: got %h expected 02", bus.grant); end
        checks++; if (bus.held !== 1'b1) begin errors++; $display("FAIL abandon_held_before: got %b expected 1", bus.held); end
        tick();
        checks++; if (bus.held !== 1'b0) begin errors++; $display("FAIL abandon_held_after: got %b expected 0", bus.held); end
        checks++; if (bus.grant !== 8'h02) begin errors++; $display("FAIL abandon_grant_after: got %h expected 02", bus.grant); end
    endtask

    task automatic test_idle_group_async_reset();
        logic [7:0] seq [5];
        seq = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h10};
        apply_reset(8'h32);
        bus.request = 8'hF0; bus.success = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.grant !== seq[i]) begin errors++; $display("FAIL idle_group[%0d]: got %h expected %h", i, bus.grant, seq[i]); end
            tick();
        end
        checks++; if (bus.grant !== 8'h20) begin errors++; $display("FAIL idle_group_next: got %h expected 20", bus.grant); end
        bus.lock = 1'b1;
        tick();
        checks++; if (bus.held !== 1'b1) begin errors++; $display("FAIL pre_reset_held: got %b expected 1", bus.held); end
        bus.lock = 1'b0; bus.success = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 8'h10) begin errors++; $display("FAIL async_reset_grant: got %h expected 10", bus.grant); end
        checks++; if (bus.held !== 1'b0) begin errors++; $display("FAIL async_reset_held: got %b expected 0", bus.held); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.request = '0;
        bus.weight  = '0;
        bus.success = 1'b0;
        bus.lock    = 1'b0;
        test_reset();
        test_weighted_rotation();
        test_no_success();
        test_success_without_grant();
        test_zero_weights();
        test_lock_burst();
        test_hold_abandon();
        test_idle_group_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lag_wrr_tree_arbiter.md
Name: lag_wrr_tree_arbiter

Overview:
- Two-level tree arbiter with weighted inter-group arbitration.
- The request vector is split into NUMGROUPS groups of GROUPSIZE. Each group runs a round-robin arbiter; groups compete through a weighted round-robin stage with a programmable per-group burst weight.
- Adds grant-hold (lock) for multi-beat transfers.
- Used for VC/switch allocation in the LAG router where flows need unequal bandwidth shares.

Parameters:
- SIZE, 20, total request lines.
- GROUPSIZE, 4, requests per group; SIZE must be an exact multiple.
- NUMGROUPS, SIZE/GROUPSIZE, derived; not overridden.
- WEIGHT_W, 4, width of each group weight field.
- HOLD_EN, 1, 1 enables the lock input; 0 ties lock off internally.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, active-low. One clock; reset is asynchronous and active-low.
- request, input, SIZE, request vector; bit i belongs to group i/GROUPSIZE.
- weight, input, NUMGROUPS*WEIGHT_W, group g weight at bits [g*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
- success, input, 1, the current grant was consumed this cycle.
- lock, input, 1, hold the current grant after this successful beat.
- grant, output, SIZE, one-hot or zero grant; combinational from request and state.
- grant_valid, output, 1, equals |request.
- held, output, 1, registered; a locked grant is active.

Behaviour:
- State, all async-cleared by rst_n low:
  - rr_ptr[g] (log2 GROUPSIZE bits), cleared to 0.
  - gptr (log2 NUMGROUPS bits), cleared to 0.
  - cnt (WEIGHT_W bits), cleared to 0.
  - held_q, cleared to 0.
  - held_idx, cleared to 0.
- Output values during and after reset:
  - held = 0.
  - grant = arbitration result from all-zero pointers, i.e. the lowest requesting index.
  - grant = 0 when request = 0.
- Intra-group arbitration: group g picks the lowest requesting index at or above rr_ptr[g], wrapping modulo GROUPSIZE.
- Inter-group arbitration: winner w is the first group with any request at or above gptr, wrapping modulo NUMGROUPS.
- Final grant is intra-group pick AND group-win; zero latency from request to grant.
- Update rule applies only on a clk edge with success=1 and grant non-zero. success with zero grant is ignored.
- Normal update (held_q=0, lock=0):
  - rr_ptr[w] <= granted_idx+1 mod GROUPSIZE.
  - base = (w==gptr) ? cnt : 0.
  - If base+1 >= eff_weight(w): gptr <= w+1 mod NUMGROUPS, cnt <= 0.
  - Else: gptr <= w, cnt <= base+1.
- Weight sampling: weight is sampled combinationally at update time. A mid-burst weight decrease ends the burst at the next success.
- Lock entry: success=1, lock=1, HOLD_EN=1, held_q=0.
  - held_q <= 1, held_idx <= granted index.
  - Pointers and cnt are frozen.
- While held_q=1 and request[held_idx]=1:
  - grant = one-hot(held_idx), ignoring all other requests.
  - success with lock=1 keeps the hold, with no state change.
  - success with lock=0 is the final beat: held_q <= 0, and the normal update is applied once for the whole burst.
- While held_q=1 and request[held_idx]=0:
  - Hold is abandoned. grant comes from normal arbitration in the same cycle and held_q <= 0 at the next edge.
  - A success in that cycle performs a normal update.
- success=0: no state changes; grant is stable while request is stable.
- Reset asserted mid-hold: held_q clears immediately (async); grant reverts to the pointer-0 result.
- Each arbitration stage is a pure function of request and state; no combinational loop through success.

Decomposition:
- Package lag_arb_pkg holds:
  - clog2-derived width constants (GIDX_W, LIDX_W).
  - the weight-field extraction function.
  - the one-hot/index conversion functions.
- Sub-module rr_ptr_arb (N, pointer in, request in, one-hot grant out, index out; combinational).
- rr_ptr_arb is instantiated NUMGROUPS times for the groups and once for group selection. All registers live in the top level.

Test Plan:
Configuration: SIZE=8, GROUPSIZE=4, weights g0=2, g1=1 unless stated.
1. Reset and weighted rotation: rst_n=0 with request=8'hFF -> grant=8'h01, held=0. Release rst_n, success=1 every cycle -> grant sequence 01,02,10,04,08,20,01,02.
2. No success: request=8'hFF, success=0 for 5 cycles -> grant stays 8'h01 and pointers are unchanged. The first success afterwards gives next grant 8'h02.
3. Zero weights: weights g0=0, g1=0, request=8'hFF, success=1 -> grant sequence 01,10,02,20,04,40.
4. Lock burst: request=8'hFF, success=1, lock=1 for 3 cycles -> grant=8'h01, held=1 from the cycle after the first edge. Then lock=0 with success -> next grant 8'h02 (burst counted as one toward g0 weight), held=0.
5. Hold abandoned: while holding index 0, request drops to 8'hFE -> same-cycle grant=8'h02, held=0 after the next edge.
6. Idle group and async reset: weight g1=3, request=8'hF0 from reset, success=1 -> grant sequence 10,20,40,80,10. Asserting rst_n mid-sequence immediately gives grant=8'h10 and held=0.
